add_round_key_seq: RTL and testbench

Sequential, parametrised AddRoundKey engine for the AES datapath. It stores the full round-key schedule (NR+1 keys) in an internal key store. It accepts a 128-bit state plus a round index over a valid/ready handshake. It XORs the selected round key into the state LANE_BYTES bytes per cycle and returns the result over a second valid/ready handshake. It sits between the key-expansion block (which fills the store) and the round datapath (SubBytes/ShiftRows/MixColumns), and serves the area-reduced AES-128/192/256 variants.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_rk_store.sv | 41 ++++
 rtl/add_round_key_seq.sv | 109 ++++++++++
 tb/tb_add_round_key_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants.
package aes_pkg;

    localparam int AES_BLOCK_BITS = 128;

    typedef logic [7:0]                byte_t;
    typedef logic [AES_BLOCK_BITS-1:0] block_t;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        HOLD
    } ark_state_e;

endpackage

// File: rtl/aes_rk_store.sv
// Round-key schedule store: one write port, one async read port.
module aes_rk_store
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] widx,
    input  block_t     wdata,
    input  logic [3:0] ridx,
    output block_t     rdata
);

    localparam logic [3:0] NR_IDX = 4'(NR);

    block_t mem [NR+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (widx <= NR_IDX)) begin
            mem[widx] <= wdata;
        end
    end

    // Out-of-range reads return zero; a same-cycle write wins.
    always_comb begin
        rdata = '0;
        if (ridx <= NR_IDX) begin
            rdata = mem[ridx];
        end
        if (we && (widx == ridx) && (ridx <= NR_IDX)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/add_round_key_seq.sv
// Sequential AddRoundKey: XORs a stored round key into the state,
// LANE_BYTES bytes per cycle, behind valid/ready handshakes.
module add_round_key_seq
    import aes_pkg::*;
#(
    parameter int LANE_BYTES = 4,
    parameter int NR         = NR_AES128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_we,
    input  logic [3:0]   key_idx,
    input  logic [127:0] key_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [3:0]   in_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_err
);

    localparam int         BEATS  = 16 / LANE_BYTES;
    localparam int         BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [3:0] NR_IDX = 4'(NR);

    ark_state_e    state_q;
    ark_state_e    state_d;
    logic [BW-1:0] beat_q;
    block_t        work_q;
    block_t        key_q;
    logic          err_q;
    block_t        rk;
    logic          accept;

    aes_rk_store #(
        .NR(NR)
    ) u_store (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (key_we),
        .widx (key_idx),
        .wdata(key_data),
        .ridx (in_round),
        .rdata(rk)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (beat_q == LAST) state_d = HOLD;
            end
            HOLD: begin
                if (accept) state_d = COMPUTE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && ((state_q == IDLE) ||
                              ((state_q == HOLD) && out_ready));
        out_valid = (state_q == HOLD);
    end

    // Accept only happens in IDLE/HOLD, so it never collides with a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            key_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            work_q <= in_state;
            key_q  <= rk;
            beat_q <= '0;
            err_q  <= (in_round > NR_IDX);
        end else if (state_q == COMPUTE) begin
            for (int k = 0; k < 16; k++) begin
                if ((k / LANE_BYTES) == int'(beat_q)) begin
                    work_q[127-8*k -: 8] <= work_q[127-8*k -: 8]
                                          ^ key_q[127-8*k -: 8];
                end
            end
            beat_q <= beat_q + 1'b1;
        end
    end

    assign out_state = work_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Directed bench for add_round_key_seq across lane widths.
module tb_add_round_key_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_we;
    logic [3:0]   key_idx;
    logic [127:0] key_data;
    logic         in_valid;
    logic [127:0] in_state;
    logic [3:0]   in_round;
    logic         out_ready;

    logic         in_ready, out_valid, out_err;
    logic [127:0] out_state;
    logic         ir1, ov1, oe1;
    logic [127:0] os1;
    logic         ir2, ov2, oe2;
    logic [127:0] os2;
    logic         ir8, ov8, oe8;
    logic [127:0] os8;
    logic         ir16, ov16, oe16;
    logic [127:0] os16;

    int total = 0;
    int fails = 0;
    int lat4, lat1, lat2, lat8, lat16;

    localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R2 = 128'h2b6f37256cfbb4d1236ebf33c512a1c3;
    localparam logic [127:0] KF = {128{1'b1}};

    always #5 clk = ~clk;

    add_round_key_seq #(.LANE_BYTES(4), .NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx),
        .key_data(key_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_round(in_round), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .out_err(out_err)
    );
    add_round_key_seq #(.LANE_BYTES(1), .NR(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx),
        .key_data(key_data), .in_valid(in_valid), .in_ready(ir1),
        .in_state(in_state), .in_round(in_round), .out_valid(ov1),
        .out_ready(out_ready), .out_state(os1), .out_err(oe1)
    );
    add_round_key_seq #(.LANE_BYTES(2), .NR(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx),
        .key_data(key_data), .in_valid(in_valid), .in_ready(ir2),
        .in_state(in_state), .in_round(in_round), .out_valid(ov2),
        .out_ready(out_ready), .out_state(os2), .out_err(oe2)
    );
    add_round_key_seq #(.LANE_BYTES(8), .NR(10)) dut8 (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx),
        .key_data(key_data), .in_valid(in_valid), .in_ready(ir8),
        .in_state(in_state), .in_round(in_round), .out_valid(ov8),
        .out_ready(out_ready), .out_state(os8), .out_err(oe8)
    );
    add_round_key_seq #(.LANE_BYTES(16), .NR(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx),
        .key_data(key_data), .in_valid(in_valid), .in_ready(ir16),
        .in_state(in_state), .in_round(in_round), .out_valid(ov16),
        .out_ready(out_ready), .out_state(os16), .out_err(oe16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_key(input logic [3:0] idx, input logic [127:0] d);
        key_we   = 1'b1;
        key_idx  = idx;
        key_data = d;
        step();
        key_we   = 1'b0;
    endtask

    task automatic accept(input logic [127:0] s, input logic [3:0] r);
        in_valid = 1'b1;
        in_state = s;
        in_round = r;
        step();
        in_valid = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; key_we = 1'b0; key_idx = '0; key_data = '0;
        in_valid = 1'b0; in_state = '0; in_round = '0; out_ready = 1'b0;
        lat4 = 0; lat1 = 0; lat2 = 0; lat8 = 0; lat16 = 0;
        steps(2);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_state", out_state, 128'h0);
        check("rst_out_err", 128'(out_err), 128'(0));
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        step();

        // FIPS-197 round 0 across all lane widths
        write_key(4'd0, K);
        in_valid = 1'b1; in_state = P; in_round = 4'd0;
        #1;
        check("idle_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (out_valid && lat4 == 0) lat4 = n;
            if (ov1 && lat1 == 0) lat1 = n;
            if (ov2 && lat2 == 0) lat2 = n;
            if (ov8 && lat8 == 0) lat8 = n;
            if (ov16 && lat16 == 0) lat16 = n;
        end
        check("lat_lane4", 128'(lat4), 128'(4));
        check("lat_lane1", 128'(lat1), 128'(16));
        check("lat_lane2", 128'(lat2), 128'(8));
        check("lat_lane8", 128'(lat8), 128'(2));
        check("lat_lane16", 128'(lat16), 128'(1));
        check("state_lane4", out_state, C);
        check("state_lane1", os1, C);
        check("state_lane2", os2, C);
        check("state_lane8", os8, C);
        check("state_lane16", os16, C);
        check("err_lane4", 128'(out_err), 128'(0));

        // Backpressure then back-to-back accept
        steps(5);
        check("bp_out_valid", 128'(out_valid), 128'(1));
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_out_state", out_state, C);
        in_valid = 1'b1; in_state = P2; in_round = 4'd0; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_compute_valid", 128'(out_valid), 128'(0));
        check("b2b_compute_ready", 128'(in_ready), 128'(0));
        steps(3);
        check("b2b_early_valid", 128'(out_valid), 128'(0));
        step();
        check("b2b_valid", 128'(out_valid), 128'(1));
        check("b2b_state", out_state, R2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_drain", 128'(out_valid), 128'(0));
        steps(20);

        // Invalid round index passes the state through
        accept(P2, 4'd11);
        steps(4);
        check("inv_valid", 128'(out_valid), 128'(1));
        check("inv_state", out_state, P2);
        check("inv_err", 128'(out_err), 128'(1));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        steps(20);

        // Key write during COMPUTE does not disturb the in-flight block
        write_key(4'd3, K);
        accept(P, 4'd3);
        write_key(4'd3, KF);
        steps(3);
        check("hz_compute_state", out_state, C);
        check("hz_compute_err", 128'(out_err), 128'(0));
        out_ready = 1'b1; step(); out_ready = 1'b0;
        steps(20);

        // Same-edge write and accept forwards the new key
        key_we = 1'b1; key_idx = 4'd3; key_data = K;
        accept(P, 4'd3);
        key_we = 1'b0;
        steps(4);
        check("hz_fwd_state", out_state, C);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        steps(20);

        // Reset in the middle of COMPUTE
        accept(P, 4'd0);
        steps(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_ready", 128'(in_ready), 128'(0));
        check("mid_rst_state", out_state, 128'h0);
        steps(2);
        rst_n = 1'b1;
        #1;
        check("mid_rst_release_ready", 128'(in_ready), 128'(1));
        steps(6);
        check("mid_rst_no_valid", 128'(out_valid), 128'(0));
        accept(P, 4'd0);
        steps(4);
        check("cleared_key_state", out_state, P);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        steps(20);
        write_key(4'd0, K);
        accept(P, 4'd0);
        steps(4);
        check("post_rst_valid", 128'(out_valid), 128'(1));
        check("post_rst_state", out_state, C);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
